// File: rtl/dma_request_controller_pkg.sv
// Shared encodings for the DMA request controller: command control codes and FSM states.
package dma_request_controller_pkg;

    localparam logic [1:0] DMA_RD_SINGLE = 2'b00;
    localparam logic [1:0] DMA_WR_SINGLE = 2'b01;
    localparam logic [1:0] DMA_RD_BURST  = 2'b10;
    localparam logic [1:0] DMA_WR_BURST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        GRANT   = 2'b10,
        RELEASE = 2'b11
    } dma_state_e;

    function automatic logic is_burst(input logic [1:0] ctrl);
        return ctrl[1];
    endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; head entry is always visible on rdata.
module dma_cmd_fifo
    import dma_request_controller_pkg::*;
#(
    parameter int WIDTH      = 40,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + (DEPTH_LOG2)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dma_request_controller.sv
// Queues host DMA commands and hands them one at a time to the DMA engine via a grant handshake.
// Optional acknowledge watchdog enabled by defining DMA_ACK_TIMEOUT_EN.
module dma_request_controller
    import dma_request_controller_pkg::*;
#(
    parameter int SIZE_BIT        = 5,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Cmd_Valid,
    input  logic [1:0]        i_Cmd_Control,
    input  logic [31:0]       i_Cmd_Pointer,
    input  logic [SIZE_BIT:0] i_Cmd_Count,
    output logic              o_Cmd_Ready,
    output logic              o_Bus_Grant,
    output logic [1:0]        o_Control,
    output logic [31:0]       o_bram_pointer,
    output logic [SIZE_BIT:0] o_Data_Counter,
    input  logic              i_Acknowlege,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Cmd_Error,
    output logic              o_Timeout
);
    localparam int CW = SIZE_BIT + 1;
    localparam int FW = 2 + 32 + CW;
    localparam logic [SIZE_BIT:0] MAX_COUNT    = {1'b1, {SIZE_BIT{1'b0}}};
    localparam logic [SIZE_BIT:0] SINGLE_COUNT = CW'(1);

    dma_state_e        state_q, state_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [SIZE_BIT:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;
    logic              cmd_accept, cmd_bad;

    // Ready is forced low while reset is held, independent of the FIFO flags.
    assign o_Cmd_Ready = i_Reset & ~fifo_full;
    assign cmd_accept  = i_Cmd_Valid & o_Cmd_Ready;
    assign cmd_bad     = is_burst(i_Cmd_Control) &&
                         ((i_Cmd_Count == '0) || (i_Cmd_Count > MAX_COUNT));
    assign fifo_push   = cmd_accept & ~cmd_bad;
    assign fifo_wdata  = {i_Cmd_Control, i_Cmd_Pointer,
                          is_burst(i_Cmd_Control) ? i_Cmd_Count : SINGLE_COUNT};
    assign err_d       = cmd_accept & cmd_bad;

    dma_cmd_fifo #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_cmd_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef DMA_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
    assign o_Timeout = tmo_q;
`else
    assign o_Timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
`ifdef DMA_ACK_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop               = 1'b1;
                    {ctrl_d, ptr_d, cnt_d} = fifo_rdata;
                    state_d                = LOAD;
                end
            end
            LOAD:    state_d = GRANT;
            GRANT: begin
                if (i_Acknowlege) begin
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end
`ifdef DMA_ACK_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMA_ACK_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef DMA_ACK_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Grant is combinational so it falls in the very cycle the acknowledge arrives.
    assign o_Bus_Grant    = (state_q == GRANT) && !i_Acknowlege;
    assign o_Busy         = (state_q == LOAD) || (state_q == GRANT);
    assign o_Control      = ctrl_q;
    assign o_bram_pointer = ptr_q;
    assign o_Data_Counter = cnt_q;
    assign o_Done         = done_q;
    assign o_Cmd_Error    = err_q;

endmodule

// File: tb/tb_dma_request_controller.sv
// Self-checking bench for dma_request_controller: per-cycle reference model, vector table,
// directed corner-case sequences and randomized traffic.
module tb_dma_request_controller;
    import dma_request_controller_pkg::*;

    localparam int SB  = 5;
    localparam int CW  = SB + 1;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n, valid, ack;
    logic [1:0]    ctrl_in;
    logic [31:0]   ptr_in;
    logic [CW-1:0] cnt_in;
    logic          o_Cmd_Ready, o_Bus_Grant, o_Busy, o_Done, o_Cmd_Error, o_Timeout;
    logic [1:0]    o_Control;
    logic [31:0]   o_bram_pointer;
    logic [CW-1:0] o_Data_Counter;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dma_request_controller #(
        .SIZE_BIT(SB), .FIFO_DEPTH_LOG2(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_Clock(clk), .i_Reset(rst_n), .i_Cmd_Valid(valid), .i_Cmd_Control(ctrl_in),
        .i_Cmd_Pointer(ptr_in), .i_Cmd_Count(cnt_in), .o_Cmd_Ready(o_Cmd_Ready),
        .o_Bus_Grant(o_Bus_Grant), .o_Control(o_Control), .o_bram_pointer(o_bram_pointer),
        .o_Data_Counter(o_Data_Counter), .i_Acknowlege(ack), .o_Busy(o_Busy),
        .o_Done(o_Done), .o_Cmd_Error(o_Cmd_Error), .o_Timeout(o_Timeout)
    );

    // Reference model: a queue of commands plus a timeline of the transfer in flight.
    // since_pop = cycles since the head was handed out (-1 = nothing in flight);
    // ack_at    = value of since_pop when the transfer ended (-1 = still waiting).
    typedef struct {
        logic [1:0]    ctrl;
        logic [31:0]   ptr;
        logic [CW-1:0] cnt;
    } cmd_t;

    cmd_t mq[$];
    cmd_t mcur;
    int   since_pop, ack_at;
    bit   m_done, m_err, m_tmo;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        mcur      = '{ctrl: 2'b00, ptr: 32'h0, cnt: '0};
        since_pop = -1;
        ack_at    = -1;
        m_done    = 0;
        m_err     = 0;
        m_tmo     = 0;
    endfunction

    function automatic bit model_in_grant();
        return (since_pop >= 1) && (ack_at < 0);
    endfunction

    function automatic void model_step();
        bit   nd, nt, ne, ready, do_pop;
        cmd_t c;
        nd = model_in_grant() && ack;
        nt = 0;
`ifdef DMA_ACK_TIMEOUT_EN
        nt = model_in_grant() && !ack && (since_pop == TMO);
`endif
        ready  = mq.size() < 4;
        do_pop = (since_pop < 0) && (mq.size() > 0);
        if (do_pop) mcur = mq.pop_front();
        ne = 0;
        if (valid && ready) begin
            if (ctrl_in[1] && (cnt_in == 0 || cnt_in > 32)) begin
                ne = 1;
            end else begin
                c.ctrl = ctrl_in;
                c.ptr  = ptr_in;
                c.cnt  = ctrl_in[1] ? cnt_in : CW'(1);
                mq.push_back(c);
            end
        end
        if (do_pop) begin
            since_pop = 0;
            ack_at    = -1;
        end else if (since_pop >= 0) begin
            if (nd || nt) ack_at = since_pop;
            since_pop++;
            if (ack_at >= 0 && since_pop > ack_at + 1) begin
                since_pop = -1;
                ack_at    = -1;
            end
        end
        m_done = nd;
        m_err  = ne;
        m_tmo  = nt;
    endfunction

    task automatic checkOutput(string name);
        logic [45:0] act, exp;
        bit e_ready, e_grant, e_busy;
        e_ready = rst_n && (mq.size() < 4);
        e_grant = rst_n && model_in_grant() && !ack;
        e_busy  = rst_n && (since_pop >= 0) && (ack_at < 0);
        act = {o_Cmd_Ready, o_Bus_Grant, o_Busy, o_Done, o_Cmd_Error, o_Timeout,
               o_Control, o_bram_pointer, o_Data_Counter};
        exp = {e_ready, e_grant, e_busy, m_done, m_err, m_tmo, mcur.ctrl, mcur.ptr, mcur.cnt};
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [31:0] p,
                                 input logic [CW-1:0] n, input logic a);
        valid   = v;
        ctrl_in = c;
        ptr_in  = p;
        cnt_in  = n;
        ack     = a;
        #1;
        checkOutput("outputs");
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
            advance();
        end
    endtask

    typedef struct {
        logic [1:0]    ctrl;
        logic [CW-1:0] cnt;
        bit            exp_err;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vt[8];
    int   dones, low, stall, issued, n;

    initial begin
        vt[0] = '{DMA_RD_SINGLE, 6'd0,  1'b0, 6'd1};
        vt[1] = '{DMA_WR_SINGLE, 6'd17, 1'b0, 6'd1};
        vt[2] = '{DMA_RD_BURST,  6'd0,  1'b1, 6'd0};
        vt[3] = '{DMA_WR_BURST,  6'd33, 1'b1, 6'd0};
        vt[4] = '{DMA_RD_BURST,  6'd1,  1'b0, 6'd1};
        vt[5] = '{DMA_WR_BURST,  6'd32, 1'b0, 6'd32};
        vt[6] = '{DMA_RD_BURST,  6'd63, 1'b1, 6'd0};
        vt[7] = '{DMA_WR_BURST,  6'd5,  1'b0, 6'd5};

        rst_n = 1'b0; valid = 1'b0; ctrl_in = '0; ptr_in = '0; cnt_in = '0; ack = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_ready", o_Cmd_Ready, 0);
        chk("reset_grant", o_Bus_Grant, 0);
        chk("reset_busy",  o_Busy, 0);
        chk("reset_ptr",   o_bram_pointer, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        chk("ready_after_reset", o_Cmd_Ready, 1);
        advance();

        // Command validation table: each command goes through a full transfer (or is rejected).
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vt[i].ctrl, 32'h1000 + 32'(i), vt[i].cnt, 1'b0);
            advance();
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
            chk($sformatf("cmd_error_%0d", i), o_Cmd_Error, vt[i].exp_err);
            advance();
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
            chk($sformatf("load_busy_%0d", i), o_Busy, !vt[i].exp_err);
            if (!vt[i].exp_err)
                chk($sformatf("load_count_%0d", i), o_Data_Counter, vt[i].exp_cnt);
            advance();
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
            advance();
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
            chk($sformatf("grant_in_ack_cycle_%0d", i), o_Bus_Grant, 0);
            advance();
            idle(2);
        end

        // Single write: count forced to 1, ack 5 grant cycles later, one done pulse.
        applyStimulus(1'b1, DMA_WR_SINGLE, 32'h100, 6'd7, 1'b0);
        advance();
        idle(1);
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        chk("single_load_count", o_Data_Counter, 1);
        chk("single_load_ptr", o_bram_pointer, 32'h100);
        chk("single_load_grant", o_Bus_Grant, 0);
        advance();
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        chk("single_grant_high", o_Bus_Grant, 1);
        advance();
        idle(4);
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
        chk("single_grant_low_on_ack", o_Bus_Grant, 0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            advance();
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
            dones += int'(o_Done);
        end
        chk("single_done_pulses", dones, 1);
        advance();
        idle(2);

        // Fill the queue while a transfer holds the bus.
        applyStimulus(1'b1, DMA_WR_BURST, 32'h200, 6'd8, 1'b0);
        advance();
        idle(2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, DMA_RD_SINGLE, 32'h300 + 32'(k), '0, 1'b0);
            chk("ready_before_full", o_Cmd_Ready, 1);
            advance();
        end
        applyStimulus(1'b1, DMA_RD_SINGLE, 32'h304, '0, 1'b0);
        chk("ready_when_full", o_Cmd_Ready, 0);
        advance();
        applyStimulus(1'b1, DMA_RD_SINGLE, 32'h304, '0, 1'b1);
        advance();
        stall = 0;
        applyStimulus(1'b1, DMA_RD_SINGLE, 32'h304, '0, 1'b0);
        while (!o_Cmd_Ready && stall < 10) begin
            advance();
            stall++;
            applyStimulus(1'b1, DMA_RD_SINGLE, 32'h304, '0, 1'b0);
        end
        chk("fifth_stall_cycles", stall, 2);
        chk("first_issued_ptr", o_bram_pointer, 32'h300);
        advance();
        issued = 1;
        n = 0;
        while (issued < 5 && n < 80) begin
            applyStimulus(1'b0, 2'b00, 32'h0, '0, (since_pop >= 2) && (ack_at < 0));
            if (since_pop == 0) begin
                chk("issue_order", o_bram_pointer, 32'h300 + 32'(issued));
                issued++;
            end
            advance();
            n++;
        end
        chk("all_issued", issued, 5);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 2'b00, 32'h0, '0, (since_pop >= 2) && (ack_at < 0));
            advance();
        end

        // Stray ack in idle, then ack held two cycles in grant; measure the regrant gap.
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
        advance();
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        chk("stray_ack_no_done", o_Done, 0);
        applyStimulus(1'b1, DMA_RD_SINGLE, 32'h400, '0, 1'b0);
        advance();
        applyStimulus(1'b1, DMA_WR_SINGLE, 32'h404, '0, 1'b0);
        advance();
        n = 0;
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        while (!o_Bus_Grant && n < 10) begin
            advance();
            n++;
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        end
        chk("grant_a_seen", o_Bus_Grant, 1);
        advance();
        dones = 0;
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
        dones += int'(o_Done);
        advance();
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
        dones += int'(o_Done);
        advance();
        low = 0;
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        while (!o_Bus_Grant && low < 20) begin
            dones += int'(o_Done);
            low++;
            advance();
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        end
        chk("held_ack_single_done", dones, 1);
        chk("regrant_idle_load_gap", low, 2);
        chk("grant_b_ptr", o_bram_pointer, 32'h404);
        advance();
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
        advance();
        idle(3);

        // Reset mid-grant with two commands still queued.
        applyStimulus(1'b1, DMA_RD_BURST, 32'h500, 6'd4, 1'b0);
        advance();
        applyStimulus(1'b1, DMA_RD_BURST, 32'h504, 6'd4, 1'b0);
        advance();
        applyStimulus(1'b1, DMA_RD_BURST, 32'h508, 6'd4, 1'b0);
        advance();
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        chk("pre_reset_grant", o_Bus_Grant, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_grant", o_Bus_Grant, 0);
        chk("async_reset_busy", o_Busy, 0);
        chk("async_reset_ready", o_Cmd_Ready, 0);
        model_reset();
        advance();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
            dones += int'(o_Done) + int'(o_Busy);
            advance();
        end
        chk("post_reset_queue_empty", dones, 0);

`ifdef DMA_ACK_TIMEOUT_EN
        // No acknowledge: watchdog ends the transfer, the next command still runs.
        applyStimulus(1'b1, DMA_WR_BURST, 32'h600, 6'd16, 1'b0);
        advance();
        applyStimulus(1'b1, DMA_RD_SINGLE, 32'h604, '0, 1'b0);
        advance();
        n = 0;
        low = 0;
        dones = 0;
        stall = 0;
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        while (o_bram_pointer != 32'h604 && n < 60) begin
            low += int'(o_Bus_Grant);
            dones += int'(o_Done);
            stall += int'(o_Timeout);
            advance();
            n++;
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b0);
        end
        chk("timeout_grant_cycles", low, TMO);
        chk("timeout_pulses", stall, 1);
        chk("timeout_no_done", dones, 0);
        chk("next_after_timeout", o_bram_pointer, 32'h604);
        advance();
        applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'b1);
        advance();
        idle(3);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
                          CW'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0));
            advance();
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 2'b00, 32'h0, '0, 1'($urandom_range(0, 1)));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
